mac_operand_fetch: RTL and testbench

// - Upstream feeder for the MAC datapath: on start, reads len operand pairs (a[i], b[i]) from two synchronous

---
 rtl/mac_operand_fetch_pkg.sv | 13 +
 rtl/mac_operand_fetch_skid_fifo.sv | 56 +++++
 rtl/mac_operand_fetch.sv | 136 +++++++++++++
 tb/tb_mac_operand_fetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_operand_fetch_pkg.sv
// Shared constants for the MAC operand fetch unit.
// FSM encodings are kept as plain 2-bit localparams for the MAC control side.
package mac_operand_fetch_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mac_operand_fetch_skid_fifo.sv
// Two-entry FIFO buffering operand pairs between memory read and consumer.
// Push and pop may coincide; illegal push (full) or pop (empty) is dropped.
module mac_skid_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_ok, push_ok;

  always_comb begin
    pop_ok   = pop && (cnt_q != 2'd0);
    push_ok  = push && ((cnt_q != 2'd2) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mac_operand_fetch.sv
// Operand feeder for the MAC: reads len (a,b) pairs from two operand
// memories and streams them out over valid/ready with a last flag.
module mac_operand_fetch
  import mac_operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_a_rdata,
  input  logic [DATA_W-1:0] mem_b_rdata,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              op_last,
  output logic              busy,
  output logic              done,
  output logic              err_len
);

  logic [1:0]          state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     issue_q, issue_d;
  logic [ADDR_W:0]     deliver_q, deliver_d;
  logic                rd_pend_q, rd_pend_d;
  logic                err_q, err_d;

  logic [1:0]          fifo_cnt;
  logic [2*DATA_W-1:0] fifo_head;
  logic                head_valid;
  logic                pop;
  logic                rd_en;
  logic [2:0]          credit;
  logic [ADDR_W:0]     last_idx;

  assign head_valid = (fifo_cnt != 2'd0);
  assign pop        = head_valid && op_ready;
  assign last_idx   = len_q - 1'b1;

  // Reads in flight plus buffered pairs never exceed the two FIFO slots.
  assign credit = {1'b0, fifo_cnt} + {2'b0, rd_pend_q} - {2'b0, pop};
  assign rd_en  = (state_q == ST_FETCH) && (issue_q < len_q) &&
                  (credit < 3'd2);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issue_d   = issue_q;
    deliver_d = deliver_q;
    rd_pend_d = rd_en;
    err_d     = 1'b0;
    if (rd_en) begin
      issue_d = issue_q + 1'b1;
    end
    if (pop) begin
      deliver_d = deliver_q + 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d   = ST_FETCH;
            len_d     = len;
            issue_d   = '0;
            deliver_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (issue_q == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && (deliver_q == last_idx)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      issue_q   <= '0;
      deliver_q <= '0;
      rd_pend_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issue_q   <= issue_d;
      deliver_q <= deliver_d;
      rd_pend_q <= rd_pend_d;
      err_q     <= err_d;
    end
  end

  mac_skid_fifo #(
    .W(2*DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pend_q),
    .push_data({mem_a_rdata, mem_b_rdata}),
    .pop      (pop),
    .count    (fifo_cnt),
    .head     (fifo_head)
  );

  assign mem_rd_en = rd_en;
  assign mem_addr  = rd_en ? issue_q[ADDR_W-1:0] : '0;
  assign op_valid  = head_valid;
  assign op_a      = head_valid ? fifo_head[2*DATA_W-1:DATA_W] : '0;
  assign op_b      = head_valid ? fifo_head[DATA_W-1:0] : '0;
  assign op_last   = head_valid && (deliver_q == last_idx);
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign err_len   = err_q;

endmodule

// File: tb/tb_mac_operand_fetch.sv
// Scoreboard bench for mac_operand_fetch with a behavioural
// synchronous operand memory and selectable consumer backpressure.
module tb_mac_operand_fetch;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_a_rdata = '0;
  logic [DW-1:0] mem_b_rdata = '0;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic          op_last;
  logic          busy;
  logic          done;
  logic          err_len;

  mac_operand_fetch #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_a_rdata(mem_a_rdata),
    .mem_b_rdata(mem_b_rdata),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_last    (op_last),
    .busy       (busy),
    .done       (done),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_a_rdata <= mem_a[mem_addr];
      mem_b_rdata <= mem_b[mem_addr];
    end
  end

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          last;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 0;
  int cur_len  = 0;
  int issued   = 0;
  int xfers    = 0;
  int lasts    = 0;
  int start_cyc;
  int first_x;
  int last_x;
  bit chk_lat  = 0;
  bit last_pend = 0;
  bit vec_done = 0;
  int ready_mode = 0;
  int rdy_ph   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Consumer: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: op_ready = 1'b1;
      1: begin
        op_ready = (rdy_ph == 0);
        rdy_ph   = (rdy_ph + 1) % 3;
      end
      default: op_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    bit   xfer;
    if (mon_en) begin
      check_eq("done", done, last_pend);
      if (done) begin
        check_eq("busy_at_done", busy, 0);
        vec_done = 1;
      end
      last_pend = 0;
      xfer = op_valid && op_ready;
      if (mem_rd_en) begin
        check_eq("mem_addr", mem_addr, issued);
        check_eq("rd_in_range", issued < cur_len, 1);
        check_eq("credit", (issued + 1 - xfers - int'(xfer)) <= 2, 1);
        issued++;
      end
      if (op_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_valid", op_valid, 0);
        end else begin
          e = sb_q[0];
          check_eq("op_a", op_a, e.a);
          check_eq("op_b", op_b, e.b);
          check_eq("op_last", op_last, e.last);
          if (xfer) begin
            if (xfers == 0) begin
              first_x = cyc;
              if (chk_lat) check_eq("first_latency", cyc + 1 - start_cyc, 3);
            end
            last_x = cyc;
            void'(sb_q.pop_front());
            xfers++;
            if (e.last) begin
              last_pend = 1;
              lasts++;
            end
          end
        end
      end
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  task automatic arm_vec(input int n);
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{a: mem_a[i], b: mem_b[i], last: (i == n - 1)});
    end
    cur_len   = n;
    issued    = 0;
    xfers     = 0;
    last_pend = 0;
    vec_done  = 0;
  endtask

  task automatic run_vec(input int n, input int inject, input bit lat);
    arm_vec(n);
    chk_lat = lat;
    @(posedge clk);
    #1;
    start     = 1'b1;
    len       = n[AW:0];
    start_cyc = cyc + 1;
    for (int i = 0; i < 600 && !vec_done; i++) begin
      @(posedge clk);
      #1;
      if (i == inject) begin
        start = 1'b1;
        len   = 5'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!vec_done) check_eq("vec_timeout", vec_done, 1);
    check_eq("xfer_count", xfers, n);
    check_eq("issue_count", issued, n);
    check_eq("sb_empty", sb_q.size(), 0);
    if (ready_mode == 0) check_eq("throughput", last_x - first_x, n - 1);
    chk_lat = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, op_valid, 0);
    check_eq({tag, "_a"}, op_a, 0);
    check_eq({tag, "_b"}, op_b, 0);
    check_eq({tag, "_last"}, op_last, 0);
    check_eq({tag, "_rd_en"}, mem_rd_en, 0);
    check_eq({tag, "_addr"}, mem_addr, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_err"}, err_len, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst   = 1'b1;
    start = 1'b0;
    len   = '0;
    fill_rand();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1;

    // basic
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(i + 5);
    end
    run_vec(4, -1, 1);

    // backpressure
    ready_mode = 1;
    fill_rand();
    run_vec(6, -1, 0);

    // boundaries
    ready_mode = 0;
    fill_rand();
    run_vec(1, -1, 1);
    fill_rand();
    run_vec(16, -1, 0);

    // zero length
    cur_len = 0;
    issued  = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("err_len_pulse", err_len, 1);
    check_eq("err_busy", busy, 0);
    @(negedge clk);
    check_eq("err_len_clear", err_len, 0);
    check_eq("err_busy2", busy, 0);

    // start while busy is ignored
    fill_rand();
    run_vec(5, 2, 0);

    // reset mid-run
    fill_rand();
    arm_vec(8);
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = 5'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100 && xfers < 2; i++) @(posedge clk);
    if (xfers < 2) check_eq("rst_wait_timeout", xfers, 2);
    #1;
    rst    = 1'b1;
    mon_en = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("midrst_no_done", done, 0);
      check_eq("midrst_no_valid", op_valid, 0);
    end
    sb_q.delete();
    last_pend = 0;
    @(posedge clk);
    #1;
    mon_en = 1;
    fill_rand();
    run_vec(2, -1, 0);

    // random
    ready_mode = 2;
    base = lasts;
    for (int v = 0; v < 200; v++) begin
      fill_rand();
      run_vec($urandom_range(1, 16), -1, 0);
    end
    check_eq("last_count", lasts - base, 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
